// File: rtl/rwl_bitser_seq_pkg.sv
// Shared constants, plane-select encoding and FSM state type for the
// read-wordline bit-serial sequencer.
package rwl_pkg;

  localparam int NIN = 144;
  localparam int XW  = 4;
  localparam int VW  = NIN * XW;

  // Bit-plane select codes, MSB plane first.
  localparam logic [3:0] SEL_B3 = 4'd0;
  localparam logic [3:0] SEL_B2 = 4'd1;
  localparam logic [3:0] SEL_B1 = 4'd2;
  localparam logic [3:0] SEL_B0 = 4'd3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [3:0] sel_of(input logic [1:0] cnt);
    return {2'b00, cnt};
  endfunction

endpackage

// File: rtl/rwl_bitser_seq_if.sv
// Activation-vector handshake plus the held bit-plane bus toward the
// read-wordline driver.
interface rwl_bitser_seq_if;
  import rwl_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_x;
  logic          in_row;

  logic [VW-1:0] xin;
  logic          cima;
  logic [3:0]    sel;
  logic          cim_vld;
  logic          cim_first;
  logic          cim_last;

  modport master (
    output in_valid, in_x, in_row,
    input  in_ready, xin, cima, sel, cim_vld, cim_first, cim_last
  );

  modport slave (
    input  in_valid, in_x, in_row,
    output in_ready, xin, cima, sel, cim_vld, cim_first, cim_last
  );

endinterface

// File: rtl/rwl_vec_buf.sv
// Register slice holding one activation vector, its row select and a valid
// flag. Load has priority over clear; clear drops only the valid flag.
module rwl_vec_buf
  import rwl_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic          clear,
  input  logic [VW-1:0] d_vec,
  input  logic          d_row,
  output logic [VW-1:0] q_vec,
  output logic          q_row,
  output logic          q_valid
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_vec   <= '0;
      q_row   <= 1'b1;
      q_valid <= 1'b0;
    end else if (load) begin
      q_vec   <= d_vec;
      q_row   <= d_row;
      q_valid <= 1'b1;
    end else if (clear) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rwl_bitser_seq.sv
// Bit-serial read-wordline sequencer: holds one activation vector and steps
// the bit-plane select MSB-first. RWL_BITSER_SEQ_DBUF_EN adds a pending slot.
//
// state | meaning
// IDLE  | no pass in progress, waiting for a vector
// RUN   | presenting planes cnt=0..3 of the held vector
module rwl_bitser_seq
  import rwl_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  rwl_bitser_seq_if.slave  bus,
  input  logic             flush,
  input  logic             cim_hold,
  output logic             busy
);

  if (XW != 4) begin : g_xw_check
    $error("rwl_bitser_seq: XW must be 4");
  end

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          rdy_en_q;
  logic          run;
  logic          end_pass;
  logic          in_ready_int;
  logic          accept;
  logic          act_load;
  logic          act_clear;
  logic [VW-1:0] act_d_vec;
  logic          act_d_row;
  logic [VW-1:0] act_vec;
  logic          act_row;
  logic          act_valid;
  logic [3:0]    sel_w;
  logic          vld_w;

  assign run      = (state_q == RUN);
  assign end_pass = run & (cnt_q == 2'd3) & ~cim_hold;

`ifdef RWL_BITSER_SEQ_DBUF_EN
  logic [VW-1:0] pend_vec;
  logic          pend_row;
  logic          pend_valid;
  logic          pend_load;
  logic          pend_clear;
  logic          promote;
  logic          take_direct;

  assign in_ready_int = rdy_en_q & ~flush & ~pend_valid;
  assign accept       = bus.in_valid & in_ready_int;
  // A vector arriving exactly at a pass boundary with nothing pending skips the slot.
  assign take_direct  = accept & (~run | (end_pass & ~pend_valid));
  assign promote      = end_pass & pend_valid & ~flush;
  assign pend_load    = accept & ~take_direct;
  assign pend_clear   = flush | promote;
  assign act_load     = take_direct | promote;
  assign act_d_vec    = promote ? pend_vec : bus.in_x;
  assign act_d_row    = promote ? pend_row : bus.in_row;
  assign busy         = run | pend_valid;

  rwl_vec_buf u_pend (
    .clk     (clk),
    .rstn    (rstn),
    .load    (pend_load),
    .clear   (pend_clear),
    .d_vec   (bus.in_x),
    .d_row   (bus.in_row),
    .q_vec   (pend_vec),
    .q_row   (pend_row),
    .q_valid (pend_valid)
  );
`else
  assign in_ready_int = rdy_en_q & ~flush & (~run | end_pass);
  assign accept       = bus.in_valid & in_ready_int;
  assign act_load     = accept;
  assign act_d_vec    = bus.in_x;
  assign act_d_row    = bus.in_row;
  assign busy         = run;
`endif

  assign act_clear = flush | (end_pass & ~act_load);

  rwl_vec_buf u_act (
    .clk     (clk),
    .rstn    (rstn),
    .load    (act_load),
    .clear   (act_clear),
    .d_vec   (act_d_vec),
    .d_row   (act_d_row),
    .q_vec   (act_vec),
    .q_row   (act_row),
    .q_valid (act_valid)
  );

  // Keeps in_ready low while reset is asserted and for the first edge after.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (act_load) begin
            state_d = RUN;
            cnt_d   = 2'd0;
          end
        end
        RUN: begin
          if (!cim_hold) begin
            if (cnt_q != 2'd3) begin
              cnt_d = cnt_q + 2'd1;
            end else begin
              cnt_d   = 2'd0;
              state_d = act_load ? RUN : IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sel_w = sel_of(cnt_q);
  assign vld_w = run & act_valid & ~cim_hold;

  assign bus.in_ready  = in_ready_int;
  assign bus.xin       = act_vec;
  assign bus.cima      = act_row;
  assign bus.sel       = sel_w;
  assign bus.cim_vld   = vld_w;
  assign bus.cim_first = vld_w & (sel_w == SEL_B3);
  assign bus.cim_last  = vld_w & (sel_w == SEL_B0);

endmodule

// File: tb/tb_rwl_bitser_seq.sv
// Bench for rwl_bitser_seq: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a queue-based plane model.
module tb_rwl_bitser_seq;
  import rwl_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  logic cim_hold = 1'b0;
  logic busy;

  rwl_bitser_seq_if bus();

  rwl_bitser_seq dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus.slave),
    .flush    (flush),
    .cim_hold (cim_hold),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: queue of accepted vectors; the front is the one on the driver,
  // 'plane' counts how many of its four planes have been delivered.
  typedef struct {
    logic [VW-1:0] vec;
    logic          row;
  } vec_t;

  vec_t q[$];
  int   plane = 0;
  int   since = 0;
  int   vld_run = 0;
  int   vld_max = 0;
  logic cima_log[$];
  logic exp_rdy, exp_vld, acc;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rstn) begin
      q.delete();
      plane = 0;
      since = 0;
      chk("rst_vld", bus.cim_vld, 0);
      chk("rst_busy", busy, 0);
    end else begin
`ifdef RWL_BITSER_SEQ_DBUF_EN
      exp_rdy = (since >= 1) && !flush && (q.size() < 2);
`else
      exp_rdy = (since >= 1) && !flush && ((q.size() == 0) || (plane == 3 && !cim_hold));
`endif
      exp_vld = (q.size() > 0) && !cim_hold;
      chk("m_in_ready", bus.in_ready, exp_rdy);
      chk("m_vld", bus.cim_vld, exp_vld);
      chk("m_first", bus.cim_first, exp_vld && plane == 0);
      chk("m_last", bus.cim_last, exp_vld && plane == 3);
      chk("m_busy", busy, q.size() > 0);
      if (q.size() > 0) begin
        chk("m_xin", bus.xin, q[0].vec);
        chk("m_cima", bus.cima, q[0].row);
        chk("m_sel", bus.sel, plane);
      end
      acc = bus.in_valid && exp_rdy;
      if (flush) begin
        q.delete();
        plane = 0;
      end else begin
        if (q.size() > 0 && !cim_hold) begin
          plane++;
          if (plane == 4) begin
            void'(q.pop_front());
            plane = 0;
          end
        end
        if (acc) q.push_back('{bus.in_x, bus.in_row});
      end
      since++;
    end
    if (rstn && bus.cim_vld) begin
      vld_run++;
      if (vld_run > vld_max) vld_max = vld_run;
      if (bus.cim_first) cima_log.push_back(bus.cima);
    end else begin
      vld_run = 0;
    end
  end

  // Offer a vector from just after a rising edge; returns just after the
  // accepting edge with in_valid still high.
  task automatic send(input logic [VW-1:0] v, input logic row);
    bit got;
    got = 0;
    bus.in_valid = 1'b1;
    bus.in_x     = v;
    bus.in_row   = row;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1;
    end
    chk("send_ready_wait", got, 1);
    @(posedge clk);
    #1;
  endtask

  logic [VW-1:0] va, vb;
  logic          exp_rows[3];
  int            last_at;
  int            strays;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    bus.in_row   = 1'b0;

    // Reset values while rstn is low.
    #12;
    chk("rst_xin", bus.xin, 0);
    chk("rst_cima", bus.cima, 1);
    chk("rst_sel", bus.sel, 0);
    chk("rst_first", bus.cim_first, 0);
    chk("rst_last", bus.cim_last, 0);
    chk("rst_ready", bus.in_ready, 0);
    @(posedge clk);
    #3 rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", bus.in_ready, 1);
    chk("idle_vld", bus.cim_vld, 0);
    chk("idle_cima", bus.cima, 1);
    chk("idle_sel", bus.sel, 0);
    @(posedge clk);
    #1;

    // Single vector 0xA5 on row 0.
    va = 576'hA5;
    send(va, 1'b0);
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("one_sel", bus.sel, k - 1);
      chk("one_vld", bus.cim_vld, 1);
      chk("one_cima", bus.cima, 0);
      chk("one_first", bus.cim_first, k == 1);
      chk("one_last", bus.cim_last, k == 4);
      chk("one_xin", bus.xin, 576'hA5);
    end
    @(negedge clk);
    chk("one_busy_end", busy, 0);
    @(posedge clk);
    #1;

    // Back-to-back stream, rows 1,0,1.
    vld_max = 0;
    cima_log.delete();
    exp_rows[0] = 1'b1;
    exp_rows[1] = 1'b0;
    exp_rows[2] = 1'b1;
    for (int i = 0; i < 3; i++) send(rand_vec(), exp_rows[i]);
    bus.in_valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("b2b_run", vld_max, 12);
    chk("b2b_passes", cima_log.size(), 3);
    for (int i = 0; i < 3 && i < cima_log.size(); i++) chk("b2b_cima", cima_log[i], exp_rows[i]);
    @(posedge clk);
    #1;

    // Hold for two cycles at cnt=1.
    send(rand_vec(), 1'b1);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 cim_hold = 1'b1;
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      chk("hold_sel", bus.sel, 1);
      chk("hold_vld", bus.cim_vld, 0);
    end
    @(posedge clk);
    #1 cim_hold = 1'b0;
    last_at = 0;
    for (int k = 4; k <= 9 && last_at == 0; k++) begin
      @(negedge clk);
      if (bus.cim_last) last_at = k;
    end
    chk("hold_last_at", last_at, 6);
    @(posedge clk);
    #1;

    // Flush at cnt=2 with a vector offered.
    send(rand_vec(), 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_x = rand_vec();
    @(negedge clk);
    chk("flush_sel", bus.sel, 2);
    chk("flush_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_vld", bus.cim_vld, 0);
    chk("flush_busy", busy, 0);
    chk("flush_ready_after", bus.in_ready, 1);
    @(negedge clk);
    chk("flush_no_accept", bus.cim_vld, 0);
    @(posedge clk);
    #1;

`ifdef RWL_BITSER_SEQ_DBUF_EN
    // Second vector handed over during the first plane of the first.
    va = rand_vec();
    vb = rand_vec();
    send(va, 1'b0);
    bus.in_x   = vb;
    bus.in_row = 1'b1;
    @(negedge clk);
    chk("dbuf_ready_c0", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk("dbuf_ready_full", bus.in_ready, 0);
    end
    chk("dbuf_v1_last", bus.cim_last, 1);
    @(negedge clk);
    chk("dbuf_v2_first", bus.cim_first, 1);
    chk("dbuf_v2_xin", bus.xin, vb);
    chk("dbuf_v2_cima", bus.cima, 1);
    chk("dbuf_ready_free", bus.in_ready, 1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
`endif

    // Reset pulse at cnt=1.
    send(rand_vec(), 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rpulse_vld", bus.cim_vld, 0);
    chk("rpulse_last", bus.cim_last, 0);
    chk("rpulse_sel", bus.sel, 0);
    chk("rpulse_cima", bus.cima, 1);
    chk("rpulse_xin", bus.xin, 0);
    chk("rpulse_busy", busy, 0);
    chk("rpulse_ready", bus.in_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rstn = 1'b1;
    strays = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.cim_last || bus.cim_vld) strays++;
    end
    chk("rpulse_no_strobes", strays, 0);
    @(posedge clk);
    #1;

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 800; c++) begin
      bus.in_valid = ($urandom_range(0, 99) < 60);
      bus.in_x     = rand_vec();
      bus.in_row   = $urandom_range(0, 1);
      cim_hold     = ($urandom_range(0, 99) < 20);
      flush        = ($urandom_range(0, 99) < 4);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    cim_hold = 1'b0;
    flush = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("final_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
